record_sampler: RTL

Capture half of the sound path. While record is held, it drives the AD7673 ADC at a fixed sample rate and turns each 18-bit conversion into a 10-bit DAC-format sample. Samples are written into an internal sample buffer. It exports `write_pointer` and a registered read port, so the playback controller can read back samples `0 .. write_pointer-1`.

---
 rtl/sound_poyo_pkg.sv | 23 ++
 rtl/sample_ram.sv | 32 +++
 rtl/record_sampler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sound_poyo_pkg.sv
// Shared types and helpers for the sound path: FSM states, sample widths and
// the ADC-to-DAC sample conversion.
package sound_poyo_pkg;

  localparam int SAMPLE_WIDTH = 10;
  localparam int ADC_WIDTH    = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV,
    S_WAIT_HI,
    S_WAIT_LO,
    S_READ,
    S_STORE
  } state_e;

  // Flipping the sign bit turns two's complement into offset binary; the top
  // SAMPLE_WIDTH bits are kept and the rest truncated.
  function automatic logic [SAMPLE_WIDTH-1:0] adc_to_sample(input logic [ADC_WIDTH-1:0] raw);
    return SAMPLE_WIDTH'((raw ^ (ADC_WIDTH'(1) << (ADC_WIDTH - 1))) >> (ADC_WIDTH - SAMPLE_WIDTH));
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port and one registered read port.
module sample_ram
  import sound_poyo_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [SAMPLE_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [SAMPLE_WIDTH-1:0] rdata
);

  logic [SAMPLE_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [SAMPLE_WIDTH-1:0] rdata_q;

  // NOTE: the array itself is never reset so it maps onto block RAM; only the
  // read register carries a reset value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/record_sampler.sv
// Capture half of the sound path: while record is held, paces AD7673
// conversions and stores each result as a 10-bit sample in the buffer.
module record_sampler
  import sound_poyo_pkg::*;
#(
  parameter int SAMPLE_INTERVAL_CLK = 6000,
  parameter int ADDR_WIDTH          = 15,
  parameter int CNV_LOW_CLK         = 2,
  parameter int RD_SETUP_CLK        = 3,
  parameter int BUSY_TIMEOUT_CLK    = 255,
  parameter int ADC_RESET_CLK       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    record_n,
  input  logic [ADDR_WIDTH-1:0]   read_pointer,
  output logic [SAMPLE_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH-1:0]   write_pointer,
  output logic                    recording,
  output logic                    adc_error,
  input  logic                    BUSY,
  input  logic [ADC_WIDTH-1:0]    AD7673_DATA,
  output logic                    CNVST_N,
  output logic                    ADC_RESET,
  output logic                    PD,
  output logic                    RD
);

  localparam int IW        = (SAMPLE_INTERVAL_CLK > 1) ? $clog2(SAMPLE_INTERVAL_CLK) : 1;
  localparam int PHASE_MAX = (CNV_LOW_CLK > RD_SETUP_CLK) ? CNV_LOW_CLK : RD_SETUP_CLK;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int WW        = $clog2(BUSY_TIMEOUT_CLK + 1);
  localparam int RW        = $clog2(ADC_RESET_CLK + 1);

  localparam logic [IW-1:0]         INTERVAL_LAST = IW'(SAMPLE_INTERVAL_CLK - 1);
  localparam logic [PW-1:0]         CNV_LAST      = PW'(CNV_LOW_CLK - 1);
  localparam logic [PW-1:0]         RD_LAST       = PW'(RD_SETUP_CLK - 1);
  localparam logic [WW-1:0]         WAIT_LAST     = WW'(BUSY_TIMEOUT_CLK - 1);
  localparam logic [RW-1:0]         ADC_RST_LAST  = RW'(ADC_RESET_CLK - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_SAMPLES   = '1;

  state_e                  state_q, state_d;
  logic [IW-1:0]           interval_q, interval_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [RW-1:0]           adc_rst_cnt_q, adc_rst_cnt_d;
  logic [ADDR_WIDTH-1:0]   wp_q, wp_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    recording_q, recording_d;
  logic                    adc_error_q, adc_error_d;
  logic                    adc_reset_q, adc_reset_d;
  logic                    record_n_prev_q, record_n_prev_d;
  logic                    run, tick, start, ram_we;

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    state_d         = state_q;
    interval_d      = interval_q;
    phase_d         = phase_q;
    wait_d          = wait_q;
    adc_rst_cnt_d   = adc_rst_cnt_q;
    wp_d            = wp_q;
    sample_d        = sample_q;
    recording_d     = recording_q;
    adc_error_d     = adc_error_q;
    adc_reset_d     = adc_reset_q;
    record_n_prev_d = record_n;
    ram_we          = 1'b0;

    if (adc_reset_q) begin
      adc_rst_cnt_d = adc_rst_cnt_q + 1'b1;
      if (adc_rst_cnt_q == ADC_RST_LAST) adc_reset_d = 1'b0;
    end

    // Releasing record stops pacing on the same edge it is seen.
    run   = recording_q && !record_n;
    tick  = run && (interval_q == INTERVAL_LAST);
    start = !record_n && record_n_prev_q && !recording_q && !adc_reset_q;
    if (run) interval_d = tick ? '0 : interval_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_CNV;
          phase_d = '0;
        end
      end
      S_CNV: begin
        if (phase_q == CNV_LAST) begin
          state_d = S_WAIT_HI;
          wait_d  = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (BUSY) begin
          state_d = S_WAIT_LO;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_IDLE;
          adc_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!BUSY) begin
          state_d = S_READ;
          phase_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_IDLE;
          adc_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_READ: begin
        if (phase_q == RD_LAST) begin
          sample_d = adc_to_sample(AD7673_DATA);
          state_d  = S_STORE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_STORE: begin
        state_d = S_IDLE;
        if (wp_q != MAX_SAMPLES) begin
          ram_we = 1'b1;
          wp_d   = wp_q + 1'b1;
          if (wp_q == MAX_SAMPLES - 1'b1) recording_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (record_n) recording_d = 1'b0;

    // A new session overrides any stale STORE from the previous one.
    if (start) begin
      wp_d        = '0;
      recording_d = 1'b1;
      interval_d  = INTERVAL_LAST;
    end
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      interval_q      <= '0;
      phase_q         <= '0;
      wait_q          <= '0;
      adc_rst_cnt_q   <= '0;
      wp_q            <= '0;
      sample_q        <= '0;
      recording_q     <= 1'b0;
      adc_error_q     <= 1'b0;
      adc_reset_q     <= 1'b1;
      record_n_prev_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      interval_q      <= interval_d;
      phase_q         <= phase_d;
      wait_q          <= wait_d;
      adc_rst_cnt_q   <= adc_rst_cnt_d;
      wp_q            <= wp_d;
      sample_q        <= sample_d;
      recording_q     <= recording_d;
      adc_error_q     <= adc_error_d;
      adc_reset_q     <= adc_reset_d;
      record_n_prev_q <= record_n_prev_d;
    end
  end

  sample_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (wp_q),
    .wdata (sample_q),
    .raddr (read_pointer),
    .rdata (read_data)
  );

  assign write_pointer = wp_q;
  assign recording     = recording_q;
  assign adc_error     = adc_error_q;
  assign ADC_RESET     = adc_reset_q;
  assign PD            = 1'b0;
  assign CNVST_N       = (state_q != S_CNV);
  assign RD            = (state_q != S_READ);

endmodule
